// File: rtl/md_sched_pkg.sv
// Shared op codes, FSM states and payload types for the multiply/divide sequencer.
package md_sched_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_res_t;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_arith.sv
// Combinational HI/LO result for mult/multu/div/divu, including signedness
// and the divide-by-zero convention (LO all ones, HI = dividend).
module md_sched_arith
  import md_sched_pkg::*;
(
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              div0
);

  logic              sgn;
  logic              neg_a;
  logic              neg_b;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] div_b;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
  always_comb begin
    sgn    = (md_op == MD_MULT) || (md_op == MD_DIV);
    neg_a  = sgn && A[DATA_W-1];
    neg_b  = sgn && B[DATA_W-1];
    prod   = {{DATA_W{neg_a}}, A} * {{DATA_W{neg_b}}, B};
    mag_a  = neg_a ? DATA_W'(~A + DATA_W'(1)) : A;
    mag_b  = neg_b ? DATA_W'(~B + DATA_W'(1)) : B;
    div0   = is_div(md_op) && (B == '0);
    div_b  = (B == '0) ? DATA_W'(1) : mag_b;
    quo    = mag_a / div_b;
    rem    = mag_a % div_b;
    res_hi = '0;
    res_lo = '0;
    if (is_mul(md_op)) begin
      {res_hi, res_lo} = prod;
    end else if (div0) begin
      res_hi = A;
      res_lo = '1;
    end else if (is_div(md_op)) begin
      res_lo = (neg_a ^ neg_b) ? DATA_W'(~quo + DATA_W'(1)) : quo;
      res_hi = neg_a ? DATA_W'(~rem + DATA_W'(1)) : rem;
    end
  end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide sequencer: latency countdown, pending result and HI/LO.
// Optional MD_DIV0_FAST_EN: divide by zero finishes after a single busy cycle.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              md_D,
  input  logic              IntReq,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy,
  output logic              stall_md
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
`ifdef MD_DIV0_FAST_EN
  localparam int unsigned DIV0_LAT = 1;
`else
  localparam int unsigned DIV0_LAT = DIV_LAT;
`endif

  md_state_e         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  md_res_t           pend, pend_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              div0;
  logic              valid_op;
  logic              accept;

  md_sched_arith u_arith (
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign valid_op = (md_op != MD_NONE) && (md_op != 3'd7);
  assign accept   = start && !IntReq && (state == ST_IDLE) && valid_op;
  assign busy     = (state == ST_BUSY);
  assign stall_md = md_D && (busy || accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
      hi_o  <= hi_d;
      lo_o  <= lo_d;
    end
  end

  // Next state: latch the result at accept, commit it when the count runs out.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_d  = pend;
    hi_d    = hi_o;
    lo_d    = lo_o;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul(md_op)) begin
            pend_d  = '{hi: res_hi, lo: res_lo};
            cnt_d   = CNT_W'(MULT_LAT);
            state_d = ST_BUSY;
          end else if (is_div(md_op)) begin
            pend_d  = '{hi: res_hi, lo: res_lo};
            cnt_d   = div0 ? CNT_W'(DIV0_LAT) : CNT_W'(DIV_LAT);
            state_d = ST_BUSY;
          end else if (md_op == MD_MTHI) begin
            hi_d = A;
          end else if (md_op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          hi_d    = pend.hi;
          lo_d    = pend.lo;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: vector table plus scoreboard, and hand
// sequences for stall, squash, ignored starts and reset during an op.
module tb_md_sched;
  import md_sched_pkg::*;

`ifdef MD_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, start, md_D, IntReq;
  logic [2:0]  md_op;
  logic [31:0] A, B, hi_o, lo_o;
  logic        busy, stall_md;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .md_D     (md_D),
    .IntReq   (IntReq),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy     (busy),
    .stall_md (stall_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op on a negedge and count the busy cycles after the accepting edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    lat = 0;
    while (busy && lat < 64) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    exp_t e;

    vecs[0]  = '{MD_MULT,  32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MD_MULTU, 32'h00000003, 32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6]  = '{MD_MTHI,  32'h00001234, 32'h0000BEEF, 32'h00001234, 32'hFFFFFFFD, 0};
    vecs[7]  = '{MD_MTLO,  32'h00005678, 32'h0000BEEF, 32'h00001234, 32'h00005678, 0};
    vecs[8]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[10] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[11] = '{MD_DIV,   32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFF, DIV0_LAT};
    vecs[12] = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, DIV0_LAT};

    reset = 1'b0; start = 1'b0; md_D = 1'b0; IntReq = 1'b0;
    md_op = 3'd0; A = '0; B = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].lat});
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      e = sb.pop_front();
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(e.lat));
      check($sformatf("vec%0d_hi", i), hi_o, e.hi);
      check($sformatf("vec%0d_lo", i), lo_o, e.lo);
    end

    // md_D held across a mult: stall on the accept cycle and every busy cycle.
    md_D = 1'b1;
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; A = 32'd3; B = 32'd4;
    #1 check("stall_accept", 32'(stall_md), 32'h1);
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check("stall_busy", 32'(stall_md), 32'h1);
      check("busy_mult", 32'(busy), 32'h1);
      @(negedge clk);
    end
    check("stall_after", 32'(stall_md), 32'h0);
    check("busy_after", 32'(busy), 32'h0);
    check("mult_lo", lo_o, 32'd12);
    check("mult_hi", hi_o, 32'd0);
    md_D = 1'b0;

    // Start and IntReq while busy are both ignored; the first op completes.
    lat = 0;
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; A = 32'd5; B = 32'd6;
    @(negedge clk);
    md_op = MD_DIV; A = 32'd100; B = 32'd3; IntReq = 1'b1;
    while (busy && lat < 64) begin
      lat++;
      @(negedge clk);
      start = 1'b0; IntReq = 1'b0; md_op = 3'd0;
    end
    check("busy_start_lat", 32'(lat), 32'd5);
    check("busy_start_lo", lo_o, 32'd30);
    check("busy_start_hi", hi_o, 32'd0);

    // IntReq squashes an accepting start: no busy, no stall, no HI/LO change.
    @(negedge clk);
    md_D = 1'b1; start = 1'b1; md_op = MD_MULT; A = 32'd7; B = 32'd7; IntReq = 1'b1;
    #1 check("squash_stall", 32'(stall_md), 32'h0);
    @(negedge clk);
    start = 1'b0; IntReq = 1'b0; md_D = 1'b0; md_op = 3'd0;
    check("squash_busy", 32'(busy), 32'h0);
    repeat (6) @(negedge clk);
    check("squash_lo", lo_o, 32'd30);
    check("squash_hi", hi_o, 32'd0);

    // Op codes 0 and 7 are ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd7; A = 32'hAAAA5555; B = 32'd2;
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    start = 1'b0;
    check("op7_busy", 32'(busy), 32'h0);
    check("op7_lo", lo_o, 32'd30);
    check("op7_hi", hi_o, 32'd0);

    // Reset on the third busy cycle of a divide discards it for good.
    @(negedge clk);
    start = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    check("rst_mid_busy_pre", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_hi", hi_o, 32'h0);
    check("rst_mid_lo", lo_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_late_hi", hi_o, 32'h0);
    check("rst_late_lo", lo_o, 32'h0);
    check("rst_late_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
